// File: rtl/pipe_result_fifo.sv
// rtl/pipe_result_fifo.sv - credit-managed result FIFO behind an unstallable fixed-latency pipe
//
// Purpose:
//   Tracks which pipe slots carry live operands with a valid delay line matched
//   to the pipe latency, captures pipe_y into a DEPTH-entry FIFO, and grants
//   upstream credit (issue_ready) only when every in-flight result is
//   guaranteed a FIFO slot.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   issue_valid/ready     upstream operand handshake; fire = valid & ready
//   pipe_y                pipe result, live when the delay line tail is set
//   out_data/valid/ready  FIFO head on a valid/ready interface
//   count                 FIFO occupancy
//   err_ovf               sticky: a live result arrived while the FIFO was full
//   stall_cnt, res_cnt    (PIPE_RES_STATS_EN only) saturating stall/pop counters
//
// Build option: define PIPE_RES_STATS_EN to add the statistics counters.
module pipe_result_fifo #(
   parameter int N     = 10,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [N-1:0]               pipe_y,
   output logic [N-1:0]               out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err_ovf
`ifdef PIPE_RES_STATS_EN
   ,
   output logic [15:0]                stall_cnt,
   output logic [15:0]                res_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   // Wide enough to hold count + inflight without wrapping.
   localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

   logic [LAT-1:0] vld_q, vld_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           err_q, err_d;
   logic [N-1:0]   mem_q [DEPTH];

   logic           fire, push, pop, full, empty;
   logic [PW-1:0]  occ;
   logic [SW-1:0]  inflight;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occ   = wr_ptr_q - rd_ptr_q;
   assign count = CW'(occ);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + SW'(vld_q[i]);
      end
   end

   // Credit counts the head being popped this cycle as still occupied, so a
   // freed slot is offered only on the following cycle.
   assign issue_ready = (SW'(occ) + inflight) < SW'(DEPTH);
   assign fire        = issue_valid & issue_ready;

   assign push      = vld_q[LAT-1] & ~full;
   assign pop       = ~empty & out_ready;
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign err_ovf   = err_q;

   always_comb begin
      vld_d    = (vld_q << 1) | LAT'(fire);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      // A live result with no room is dropped; only a credit bug gets here.
      err_d    = err_q | (vld_q[LAT-1] & full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: out_data is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= pipe_y;
      end
   end

`ifdef PIPE_RES_STATS_EN
   logic [15:0] stall_q, res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         res_q   <= '0;
      end else begin
         if (issue_valid && !issue_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (pop && (res_q != 16'hFFFF)) begin
            res_q <= res_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign res_cnt   = res_q;
`endif

endmodule
